// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the accumulator-processor control unit.
//   - state_t     : 4-bit state encoding (START ... HALT)
//   - OP_*        : opcode values found in IR[7:5]
//   - ASEL_*      : accumulator input mux selections
//   - ctrl_out_t  : bundle of every DataPath control strobe
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_START  = 4'b0000,
        S_FETCH  = 4'b0001,
        S_DECODE = 4'b0010,
        S_LOAD   = 4'b1000,
        S_STORE  = 4'b1001,
        S_ADD    = 4'b1010,
        S_SUB    = 4'b1011,
        S_INPUT  = 4'b1100,
        S_JZ     = 4'b1101,
        S_JPOS   = 4'b1110,
        S_HALT   = 4'b1111
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

    typedef struct packed {
        logic       irload;
        logic       jmpmux;
        logic       pcload;
        logic       meminst;
        logic       memwr;
        logic [1:0] asel;
        logic       aload;
        logic       sub;
        logic       halt;
    } ctrl_out_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational output decode for ctrl_unit.
// Ports:
//   state  in   current FSM state
//   Aeq0   in   accumulator == 0 (drives PCload in JZ)
//   Apos   in   accumulator > 0  (drives PCload in JPOS)
//   Enter  in   operator key strobe (only used with CTRL_INPUT_HANDSHAKE_EN)
//   ctrl   out  all DataPath control strobes
// Optional macro CTRL_INPUT_HANDSHAKE_EN: INPUT loads A only while Enter = 1.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t    state,
    input  logic      Aeq0,
    input  logic      Apos,
    input  logic      Enter,
    output ctrl_out_t ctrl
);

`ifndef CTRL_INPUT_HANDSHAKE_EN
    logic unused_enter;
    assign unused_enter = Enter;
`endif

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.irload = 1'b1;
                ctrl.pcload = 1'b1;
            end
            S_DECODE: begin
                ctrl.meminst = 1'b1;
            end
            S_LOAD: begin
                ctrl.meminst = 1'b1;
                ctrl.asel    = ASEL_RAM;
                ctrl.aload   = 1'b1;
            end
            S_STORE: begin
                ctrl.meminst = 1'b1;
                ctrl.memwr   = 1'b1;
            end
            S_ADD: begin
                ctrl.meminst = 1'b1;
                ctrl.asel    = ASEL_ALU;
                ctrl.aload   = 1'b1;
            end
            S_SUB: begin
                ctrl.meminst = 1'b1;
                ctrl.asel    = ASEL_ALU;
                ctrl.aload   = 1'b1;
                ctrl.sub     = 1'b1;
            end
            S_INPUT: begin
                ctrl.asel  = ASEL_IN;
`ifdef CTRL_INPUT_HANDSHAKE_EN
                ctrl.aload = Enter;
`else
                ctrl.aload = 1'b1;
`endif
            end
            S_JZ: begin
                ctrl.jmpmux = 1'b1;
                ctrl.pcload = Aeq0;
            end
            S_JPOS: begin
                ctrl.jmpmux = 1'b1;
                ctrl.pcload = Apos;
            end
            S_HALT: begin
                ctrl.halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: control FSM for the 8-bit accumulator processor.
// Holds the state register and next-state logic; outputs come from
// ctrl_out_decode and wire one-to-one to the same-named DataPath inputs.
// Ports:
//   clk, clear (sync active-low), Enter, IR75[2:0], Aeq0, Apos   inputs
//   IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub,
//   Halt, state[STATE_W-1:0]                                     outputs
// Optional macro CTRL_INPUT_HANDSHAKE_EN: INPUT waits for Enter.
//
// state  | meaning
// -------+-------------------------------------------------
// START  | idle step between instructions, all strobes off
// FETCH  | IR <- RAM[PC], PC <- PC+1
// DECODE | address RAM from IR[4:0], pick execute state
// LOAD   | A <- RAM[IR[4:0]]
// STORE  | RAM[IR[4:0]] <- A
// ADD    | A <- A + RAM[IR[4:0]]
// SUB    | A <- A - RAM[IR[4:0]]
// INPUT  | A <- external input
// JZ     | PC <- IR[4:0] if A == 0
// JPOS   | PC <- IR[4:0] if A > 0
// HALT   | stopped until clear
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               Enter,
    input  logic [2:0]         IR75,
    input  logic               Aeq0,
    input  logic               Apos,
    output logic               IRload,
    output logic               JMPmux,
    output logic               PCload,
    output logic               Meminst,
    output logic               MemWr,
    output logic [1:0]         Asel,
    output logic               Aload,
    output logic               Sub,
    output logic               Halt,
    output logic [STATE_W-1:0] state
);

    state_t    state_q;
    state_t    state_d;
    ctrl_out_t ctrl;

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Unencoded register values fall into the default arm and recover to START.
    always_comb begin
        state_d = S_START;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (IR75)
                    OP_LOAD:  state_d = S_LOAD;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_INPUT: state_d = S_INPUT;
                    OP_JZ:    state_d = S_JZ;
                    OP_JPOS:  state_d = S_JPOS;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_START;
                endcase
            end
`ifdef CTRL_INPUT_HANDSHAKE_EN
            S_INPUT:  state_d = Enter ? S_START : S_INPUT;
`else
            S_INPUT:  state_d = S_START;
`endif
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_START;
        endcase
    end

    ctrl_out_decode u_out_decode (
        .state (state_q),
        .Aeq0  (Aeq0),
        .Apos  (Apos),
        .Enter (Enter),
        .ctrl  (ctrl)
    );

    assign IRload  = ctrl.irload;
    assign JMPmux  = ctrl.jmpmux;
    assign PCload  = ctrl.pcload;
    assign Meminst = ctrl.meminst;
    assign MemWr   = ctrl.memwr;
    assign Asel    = ctrl.asel;
    assign Aload   = ctrl.aload;
    assign Sub     = ctrl.sub;
    assign Halt    = ctrl.halt;
    assign state   = STATE_W'(state_q);

endmodule
